// File: rtl/ub_affine_loop_ctrl_if.sv
// Handshake, configuration and schedule outputs of one affine loop controller.
interface ub_affine_loop_ctrl_if #(
  parameter int W     = 16,
  parameter int NVARS = 4
);
  logic         flush;
  logic         start;
  logic         stall;
  logic [W-1:0] cfg_start_delay;
  logic [W-1:0] cfg_ii;
  logic [W-1:0] cfg_ext1;
  logic [W-1:0] cfg_ext2;
  logic [W-1:0] cfg_ext3;
  logic         op_en;
  logic [W-1:0] ctrl_vars [NVARS-1:0];
  logic         busy;
  logic         done;
  logic         cfg_err;

  modport master (
    output flush, start, stall, cfg_start_delay, cfg_ii, cfg_ext1, cfg_ext2, cfg_ext3,
    input  op_en, ctrl_vars, busy, done, cfg_err
  );

  modport slave (
    input  flush, start, stall, cfg_start_delay, cfg_ii, cfg_ext1, cfg_ext2, cfg_ext3,
    output op_en, ctrl_vars, busy, done, cfg_err
  );
endinterface

// File: rtl/ub_affine_loop_ctrl.sv
// Schedule controller: walks a 3-level affine loop nest after a start delay,
// issuing one registered enable every II non-stalled cycles.
module ub_affine_loop_ctrl #(
  parameter int W     = 16,
  parameter int NVARS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ub_affine_loop_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ii_q, ext1_q, ext2_q, ext3_q;
  logic [W-1:0] i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [W-1:0] cv_q [1:NVARS-1];
  logic [W-1:0] cv1_d, cv2_d, cv3_d;
  logic         last_q, last_d;
  logic         op_en_q, op_en_d;
  logic         cfg_err_q, cfg_err_d;
  logic         lat_cfg, fire, cfg_ok;
  logic [W-1:0] e1, e2, e3, ii_sel, c1, c2, c3;

  always_comb begin
    cfg_ok = (bus.cfg_ii != '0) && (bus.cfg_ext1 != '0) &&
             (bus.cfg_ext2 != '0) && (bus.cfg_ext3 != '0);
    // On the launch edge the config and issue point come straight from the inputs
    if (state_q == IDLE) begin
      e1 = bus.cfg_ext1; e2 = bus.cfg_ext2; e3 = bus.cfg_ext3; ii_sel = bus.cfg_ii;
      c1 = '0;           c2 = '0;           c3 = '0;
    end else begin
      e1 = ext1_q; e2 = ext2_q; e3 = ext3_q; ii_sel = ii_q;
      c1 = i1_q;   c2 = i2_q;   c3 = i3_q;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    cv1_d     = cv_q[1];
    cv2_d     = cv_q[2];
    cv3_d     = cv_q[3];
    last_d    = last_q;
    op_en_d   = 1'b0;
    cfg_err_d = 1'b0;
    lat_cfg   = 1'b0;
    fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!cfg_ok) begin
            cfg_err_d = 1'b1;
          end else begin
            lat_cfg = 1'b1;
            last_d  = 1'b0;
            i1_d    = '0;
            i2_d    = '0;
            i3_d    = '0;
            if (bus.cfg_start_delay == '0) begin
              fire    = 1'b1;
              state_d = RUN;
            end else begin
              cnt_d   = bus.cfg_start_delay - ONE;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT, RUN: begin
        if (last_q) begin
          state_d = DONE;
        end else if (!bus.stall) begin
          if (cnt_q == '0) begin
            fire    = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Issue the current index and step to its outer-major successor
    if (fire) begin
      op_en_d = 1'b1;
      cv1_d   = c1;
      cv2_d   = c2;
      cv3_d   = c3;
      cnt_d   = ii_sel - ONE;
      last_d  = (c1 == e1 - ONE) && (c2 == e2 - ONE) && (c3 == e3 - ONE);
      i1_d    = c1;
      i2_d    = c2;
      i3_d    = c3 + ONE;
      if (c3 == e3 - ONE) begin
        i3_d = '0;
        i2_d = c2 + ONE;
        if (c2 == e2 - ONE) begin
          i2_d = '0;
          i1_d = (c1 == e1 - ONE) ? '0 : c1 + ONE;
        end
      end
    end

    if (bus.flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      i1_d      = '0;
      i2_d      = '0;
      i3_d      = '0;
      cv1_d     = '0;
      cv2_d     = '0;
      cv3_d     = '0;
      last_d    = 1'b0;
      op_en_d   = 1'b0;
      cfg_err_d = 1'b0;
      lat_cfg   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ii_q      <= '0;
      ext1_q    <= '0;
      ext2_q    <= '0;
      ext3_q    <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      last_q    <= 1'b0;
      op_en_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int v = 1; v < NVARS; v++) cv_q[v] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      last_q    <= last_d;
      op_en_q   <= op_en_d;
      cfg_err_q <= cfg_err_d;
      cv_q[1]   <= cv1_d;
      cv_q[2]   <= cv2_d;
      cv_q[3]   <= cv3_d;
      if (lat_cfg) begin
        ii_q   <= bus.cfg_ii;
        ext1_q <= bus.cfg_ext1;
        ext2_q <= bus.cfg_ext2;
        ext3_q <= bus.cfg_ext3;
      end
    end
  end

  assign bus.op_en        = op_en_q;
  assign bus.busy         = (state_q == WAIT) || (state_q == RUN);
  assign bus.done         = (state_q == DONE);
  assign bus.cfg_err      = cfg_err_q;
  assign bus.ctrl_vars[0] = '0;
  for (genvar v = 1; v < NVARS; v++) begin : g_cv
    assign bus.ctrl_vars[v] = cv_q[v];
  end
endmodule
